// File: rtl/axi_4lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_4lite_regfile
//
// AXI4-Lite slave exposing NUM_REGS word-wide registers to the user datapath.
// Read/write registers are updated through byte strobes. Read-only registers
// return hardware status values. Each successful register write produces a
// one-cycle wr_pulse strobe for that register.
//
// Ports
//   AXI_aclk, AXI_areset        clock, synchronous active-high reset
//   AXI_aw*, AXI_w*, AXI_b*     write address / data / response channels
//   AXI_ar*, AXI_r*             read address / data channels
//                               (AXI_areadaddr is the read byte address)
//   reg_out                     flattened register contents, reg i at [i*DW +: DW]
//   status_in                   hardware values returned for read-only registers
//   wr_pulse                    one-cycle strobe per successful register write
// ---------------------------------------------------------------------------
module axi_4lite_regfile #(
   parameter int                     AXI_Dwidth    = 32,
   parameter int                     AXI_Addrwidth = 6,
   parameter int                     NUM_REGS      = 8,
   parameter logic [NUM_REGS-1:0]    RO_MASK       = '0,
   parameter logic [AXI_Dwidth-1:0]  RESET_VALUE   = '0
) (
   input  logic                           AXI_aclk,
   input  logic                           AXI_areset,
   input  logic [AXI_Addrwidth-1:0]       AXI_awaddr,
   input  logic [2:0]                     AXI_awprotect,
   input  logic                           AXI_awvalid,
   output logic                           AXI_awready,
   input  logic [AXI_Dwidth-1:0]          AXI_wdata,
   input  logic [AXI_Dwidth/8-1:0]        AXI_wstrb,
   input  logic                           AXI_wvalid,
   output logic                           AXI_wready,
   output logic [1:0]                     AXI_bresp,
   output logic                           AXI_bvalid,
   input  logic                           AXI_bready,
   input  logic [AXI_Addrwidth-1:0]       AXI_areadaddr,
   input  logic [2:0]                     AXI_arprotect,
   input  logic                           AXI_arvalid,
   output logic                           AXI_arready,
   output logic [AXI_Dwidth-1:0]          AXI_rdata,
   output logic [1:0]                     AXI_rresp,
   output logic                           AXI_rvalid,
   input  logic                           AXI_rready,
   output logic [NUM_REGS*AXI_Dwidth-1:0] reg_out,
   input  logic [NUM_REGS*AXI_Dwidth-1:0] status_in,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int STRBW = AXI_Dwidth / 8;
   localparam int ASB   = $clog2(STRBW);
   localparam int IDXW  = AXI_Addrwidth - ASB;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                  awHeld_q, awHeld_d;
   logic [IDXW-1:0]       awIdx_q, awIdx_d;
   logic                  wHeld_q, wHeld_d;
   logic [AXI_Dwidth-1:0] wData_q, wData_d;
   logic [STRBW-1:0]      wStrb_q, wStrb_d;
   logic                  bValid_q, bValid_d;
   logic [1:0]            bResp_q, bResp_d;
   logic [NUM_REGS-1:0]   wrPulse_q, wrPulse_d;
   logic                  rValid_q, rValid_d;
   logic [AXI_Dwidth-1:0] rData_q, rData_d;
   logic [1:0]            rResp_q, rResp_d;
   logic [AXI_Dwidth-1:0] regs_q [NUM_REGS];
   logic [AXI_Dwidth-1:0] regs_d [NUM_REGS];

   logic            awReady, wReady, arReady;
   logic            awFire, wFire, arFire;
   logic [IDXW-1:0] awIdxIn, arIdxIn;
   logic            unusedBits;

   // Word index of each incoming address; the byte offset inside a word is dropped.
   assign awIdxIn = AXI_awaddr[AXI_Addrwidth-1:ASB];
   assign arIdxIn = AXI_areadaddr[AXI_Addrwidth-1:ASB];

   // Protection bits and byte offsets carry no meaning for this slave.
   assign unusedBits = ^{AXI_awprotect, AXI_arprotect, AXI_awaddr[ASB-1:0],
                         AXI_areadaddr[ASB-1:0], status_in};

   // Readies are forced low while reset is asserted so nothing is accepted
   // until the cycle after reset goes away. A pending write response blocks
   // both write-side readies so at most one write is ever in flight.
   assign awReady = !AXI_areset && !awHeld_q && !bValid_q;
   assign wReady  = !AXI_areset && !wHeld_q && !bValid_q;
   assign arReady = !AXI_areset && !rValid_q;

   assign awFire = AXI_awvalid && awReady;
   assign wFire  = AXI_wvalid && wReady;
   assign arFire = AXI_arvalid && arReady;

   // Next-state logic for both channels. AW and W are captured independently
   // into holding registers; once both are held the write commits on the
   // following edge. Reads sample regs_q (not regs_d), so a read and a commit
   // to the same register on the same edge return the pre-write value.
   always_comb begin
      awHeld_d  = awHeld_q;
      awIdx_d   = awIdx_q;
      wHeld_d   = wHeld_q;
      wData_d   = wData_q;
      wStrb_d   = wStrb_q;
      bValid_d  = bValid_q;
      bResp_d   = bResp_q;
      wrPulse_d = '0;
      rValid_d  = rValid_q;
      rData_d   = rData_q;
      rResp_d   = rResp_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end

      if (awFire) begin
         awHeld_d = 1'b1;
         awIdx_d  = awIdxIn;
      end
      if (wFire) begin
         wHeld_d = 1'b1;
         wData_d = AXI_wdata;
         wStrb_d = AXI_wstrb;
      end

      if (bValid_q && AXI_bready) begin
         bValid_d = 1'b0;
      end

      // Commit: an index that matches no writable register falls through as SLVERR.
      if (awHeld_q && wHeld_q) begin
         awHeld_d = 1'b0;
         wHeld_d  = 1'b0;
         bValid_d = 1'b1;
         bResp_d  = RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (awIdx_q == IDXW'(i) && !RO_MASK[i]) begin
               bResp_d      = RESP_OKAY;
               wrPulse_d[i] = 1'b1;
               for (int k = 0; k < STRBW; k++) begin
                  if (wStrb_q[k]) begin
                     regs_d[i][k*8 +: 8] = wData_q[k*8 +: 8];
                  end
               end
            end
         end
      end

      if (rValid_q && AXI_rready) begin
         rValid_d = 1'b0;
      end

      if (arFire) begin
         rValid_d = 1'b1;
         rData_d  = '0;
         rResp_d  = RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (arIdxIn == IDXW'(i)) begin
               rResp_d = RESP_OKAY;
               rData_d = RO_MASK[i] ? status_in[i*AXI_Dwidth +: AXI_Dwidth] : regs_q[i];
            end
         end
      end
   end

   // State registers. Reset discards any half-finished transaction on either channel.
   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset) begin
         awHeld_q  <= 1'b0;
         awIdx_q   <= '0;
         wHeld_q   <= 1'b0;
         wData_q   <= '0;
         wStrb_q   <= '0;
         bValid_q  <= 1'b0;
         bResp_q   <= RESP_OKAY;
         wrPulse_q <= '0;
         rValid_q  <= 1'b0;
         rData_q   <= '0;
         rResp_q   <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VALUE;
         end
      end else begin
         awHeld_q  <= awHeld_d;
         awIdx_q   <= awIdx_d;
         wHeld_q   <= wHeld_d;
         wData_q   <= wData_d;
         wStrb_q   <= wStrb_d;
         bValid_q  <= bValid_d;
         bResp_q   <= bResp_d;
         wrPulse_q <= wrPulse_d;
         rValid_q  <= rValid_d;
         rData_q   <= rData_d;
         rResp_q   <= rResp_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Flatten the register array onto the user-side bus.
   for (genvar g = 0; g < NUM_REGS; g++) begin : gRegOut
      assign reg_out[g*AXI_Dwidth +: AXI_Dwidth] = regs_q[g];
   end

   assign AXI_awready = awReady;
   assign AXI_wready  = wReady;
   assign AXI_arready = arReady;
   assign AXI_bvalid  = bValid_q;
   assign AXI_bresp   = bResp_q;
   assign AXI_rvalid  = rValid_q;
   assign AXI_rdata   = rData_q;
   assign AXI_rresp   = rResp_q;
   assign wr_pulse    = wrPulse_q;

endmodule
